// File: rtl/acoustic_capture_buffer.sv
// acoustic_capture_buffer
// Pre/post-trigger circular capture buffer for deserialised ADC samples.
// While armed, samples stream into a block-RAM ring. A trigger starts a
// fixed-length post-trigger capture, after which the ring freezes and is
// read back oldest-first through a logical index.
module acoustic_capture_buffer #(
  parameter int WORD_SIZE = 10,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 arm,
  input  logic                 trigger,
  input  logic                 sample_valid,
  input  logic [WORD_SIZE-1:0] sample_in,
  input  logic                 rd_en,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [WORD_SIZE-1:0] rd_data,
  output logic                 rd_valid,
  output logic [1:0]           state,
  output logic                 done,
  output logic [ADDR_W:0]      sample_count,
  output logic [ADDR_W:0]      trig_pos
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_POST  = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C     = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] POST_TRIG_C = (ADDR_W + 1)'(POST_TRIG);

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]       count_q, count_d;
  logic [ADDR_W:0]       post_cnt_q, post_cnt_d;
  logic [WORD_SIZE-1:0]  rd_data_q;
  logic                  rd_valid_q;

  logic                  wr_en;
  logic                  rd_accept;
  logic                  post_last;
  logic [ADDR_W:0]       post_cnt_inc;
  logic [ADDR_W-1:0]     base;
  logic [ADDR_W-1:0]     rd_phys;

  logic [WORD_SIZE-1:0]  mem [DEPTH];

  assign post_cnt_inc = post_cnt_q + 1'b1;
  assign post_last    = (post_cnt_inc == POST_TRIG_C);

  // Oldest stored sample sits sample_count slots behind the write pointer;
  // a full ring makes the low bits of the count zero so base == wr_ptr.
  assign base    = wr_ptr_q - count_q[ADDR_W-1:0];
  assign rd_phys = base + rd_addr;

  // State register
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; arm overrides everything else
  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = S_ARMED;
    end else begin
      case (state_q)
        S_ARMED: if (trigger)            state_d = S_POST;
        S_POST:  if (wr_en && post_last) state_d = S_DONE;
        default: ;
      endcase
    end
  end

  // Output / control decode from the current state
  always_comb begin
    wr_en     = !arm && sample_valid && (state_q == S_ARMED || state_q == S_POST);
    rd_accept = rd_en && (state_q == S_DONE) && ({1'b0, rd_addr} < count_q);
    done      = (state_q == S_DONE);
  end

  // Pointer, fill count and post-trigger count next values
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    post_cnt_d = post_cnt_q;
    if (arm) begin
      wr_ptr_d   = '0;
      count_d    = '0;
      post_cnt_d = '0;
    end else if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (count_q != DEPTH_C) count_d = count_q + 1'b1;
      // A sample coincident with the trigger is still pre-trigger
      if (state_q == S_POST) post_cnt_d = post_cnt_inc;
    end else if (state_q == S_ARMED && trigger) begin
      post_cnt_d = '0;
    end
  end

  // Pointer and counter registers
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr_q   <= '0;
      count_q    <= '0;
      post_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      post_cnt_q <= post_cnt_d;
    end
  end

  // Sample RAM write port; contents are intentionally never cleared
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= sample_in;
  end

  // Registered read port; data holds its last value when no read is accepted
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_accept;
      if (rd_accept) rd_data_q <= mem[rd_phys];
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign state        = state_q;
  assign sample_count = count_q;
  assign trig_pos     = done ? (count_q - POST_TRIG_C) : '0;

endmodule

// File: tb/tb_acoustic_capture_buffer.sv
// tb_acoustic_capture_buffer
// Directed bench for the capture buffer at DEPTH=16, POST_TRIG=4, 10-bit samples.
module tb_acoustic_capture_buffer;

  logic       clk;
  logic       reset_b;
  logic       arm;
  logic       trigger;
  logic       sample_valid;
  logic [9:0] sample_in;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [9:0] rd_data;
  logic       rd_valid;
  logic [1:0] state;
  logic       done;
  logic [4:0] sample_count;
  logic [4:0] trig_pos;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] addr;
    logic       en;
    logic       exp_valid;
    logic [9:0] exp_data;
  } rd_vec_t;

  rd_vec_t vecs [17];

  acoustic_capture_buffer #(
    .WORD_SIZE(10),
    .DEPTH(16),
    .POST_TRIG(4)
  ) dut (
    .clk(clk),
    .reset_b(reset_b),
    .arm(arm),
    .trigger(trigger),
    .sample_valid(sample_valid),
    .sample_in(sample_in),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .state(state),
    .done(done),
    .sample_count(sample_count),
    .trig_pos(trig_pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("check %s: got %0d", name, act);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    arm = 0; trigger = 0; sample_valid = 0; sample_in = '0; rd_en = 0; rd_addr = '0;
  endtask

  task automatic do_arm();
    arm = 1; cyc(); arm = 0;
  endtask

  task automatic push(input int v, input logic trig);
    sample_valid = 1; sample_in = 10'(v); trigger = trig;
    cyc();
    sample_valid = 0; trigger = 0;
  endtask

  task automatic pulse_trig();
    trigger = 1; cyc(); trigger = 0;
  endtask

  task automatic read1(input int a);
    rd_en = 1; rd_addr = 4'(a); cyc(); rd_en = 0;
  endtask

  initial begin
    // Read table for the wrap-around capture: oldest sample is 9, newest 24
    for (int i = 0; i < 16; i++) vecs[i] = '{4'(i), 1'b1, 1'b1, 10'(9 + i)};
    vecs[16] = '{4'd0, 1'b0, 1'b0, 10'd24};

    idle_inputs();
    reset_b = 0;
    // Reset held: toggling inputs must not disturb anything
    repeat (2) cyc();
    arm = 1; trigger = 1; sample_valid = 1; sample_in = 10'h3ff; rd_en = 1; rd_addr = 4'd3;
    cyc();
    arm = 0; cyc();
    check("rst_state", state, 0);
    check("rst_done", done, 0);
    check("rst_count", sample_count, 0);
    check("rst_trigpos", trig_pos, 0);
    check("rst_rddata", rd_data, 0);
    check("rst_rdvalid", rd_valid, 0);
    idle_inputs();
    reset_b = 1;
    cyc();
    check("post_rst_idle", state, 0);

    // Trigger and samples in IDLE are ignored
    trigger = 1; sample_valid = 1; sample_in = 10'd7; cyc(); idle_inputs();
    check("idle_trig_state", state, 0);
    check("idle_sample_count", sample_count, 0);

    // Wrap-around: samples 1..20, trigger, samples 21..24
    do_arm();
    check("arm_state", state, 1);
    for (int v = 1; v <= 20; v++) push(v, 1'b0);
    check("wrap_count_sat", sample_count, 16);
    read1(0);
    check("armed_read_ignored", rd_valid, 0);
    pulse_trig();
    check("wrap_post_state", state, 2);
    for (int v = 21; v <= 23; v++) push(v, 1'b0);
    check("wrap_still_post", state, 2);
    read1(0);
    check("post_read_ignored", rd_valid, 0);
    push(24, 1'b0);
    check("wrap_done", done, 1);
    check("wrap_state", state, 3);
    check("wrap_count", sample_count, 16);
    check("wrap_trigpos", trig_pos, 12);
    // Frozen: further samples are not stored
    push(500, 1'b0);
    check("done_frozen_count", sample_count, 16);

    // Back-to-back reads from the table, one result per cycle
    for (int i = 0; i < 17; i++) begin
      rd_en = vecs[i].en; rd_addr = vecs[i].addr;
      cyc();
      check($sformatf("wrap_rd%0d_valid", i), rd_valid, vecs[i].exp_valid);
      check($sformatf("wrap_rd%0d_data", i), rd_data, vecs[i].exp_data);
    end
    rd_en = 0;
    read1(12);
    check("wrap_trig_sample", rd_data, 21);

    // Partial fill
    do_arm();
    check("rearm_count", sample_count, 0);
    push(100, 1'b0); push(101, 1'b0); push(102, 1'b0);
    pulse_trig();
    for (int v = 103; v <= 106; v++) push(v, 1'b0);
    check("part_done", done, 1);
    check("part_count", sample_count, 7);
    check("part_trigpos", trig_pos, 3);
    read1(0);
    check("part_idx0_valid", rd_valid, 1);
    check("part_idx0", rd_data, 100);
    read1(6);
    check("part_idx6", rd_data, 106);
    read1(7);
    check("part_idx7_valid", rd_valid, 0);
    check("part_idx7_hold", rd_data, 106);

    // Simultaneous trigger and sample: sample 5 is pre-trigger
    do_arm();
    for (int v = 1; v <= 4; v++) push(v, 1'b0);
    push(5, 1'b1);
    check("sim_post", state, 2);
    for (int v = 6; v <= 8; v++) push(v, 1'b0);
    check("sim_not_done_at8", state, 2);
    push(9, 1'b0);
    check("sim_done_at9", state, 3);
    check("sim_trigpos", trig_pos, 5);
    read1(5);
    check("sim_idx5", rd_data, 6);

    // Arm together with a sample: arm wins, sample dropped
    arm = 1; sample_valid = 1; sample_in = 10'd77; cyc(); idle_inputs();
    check("arm_sample_state", state, 1);
    check("arm_sample_count", sample_count, 0);

    // Trigger during POST must not restart the post-trigger count
    push(10, 1'b0);
    pulse_trig();
    push(11, 1'b0); push(12, 1'b0);
    pulse_trig();
    push(13, 1'b0);
    check("post_trig_ignored_post", state, 2);
    push(14, 1'b0);
    check("post_trig_ignored_done", state, 3);
    check("post_trig_count", sample_count, 5);

    // Asynchronous reset mid-POST
    do_arm();
    push(1, 1'b0); pulse_trig(); push(2, 1'b0); push(3, 1'b0);
    #2 reset_b = 0;
    #1;
    check("async_rst_state", state, 0);
    check("async_rst_count", sample_count, 0);
    cyc();
    reset_b = 1;
    cyc();
    check("after_rst_idle", state, 0);
    do_arm();
    for (int v = 31; v <= 35; v++) push(v, 1'b0);
    pulse_trig();
    for (int v = 36; v <= 39; v++) push(v, 1'b0);
    check("rst_recap_done", done, 1);
    check("rst_recap_count", sample_count, 9);
    read1(8);
    check("rst_recap_last", rd_data, 39);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stuck run
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
